// File: rtl/udp_sched_pkg.sv
// udp_sched_pkg
//   Shared definitions for the UDP start scheduler: the FSM state type and
//   the bit positions of the fields inside the control word.
//   No ports; imported by udp_start_sched and its testbench.
package udp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int START_BIT   = 0;
  localparam int STOP_BIT    = 1;
  localparam int PKT_CNT_LSB = 8;
  localparam int PKT_CNT_MSB = 15;
  localparam int GAP_LSB     = 16;
  localparam int GAP_MSB     = 31;

endpackage

// File: rtl/udp_sched_timer.sv
// udp_sched_timer
//   Loadable down-counter with a zero flag. Used for the inter-packet gap
//   and, when enabled, for the WAIT_DONE watchdog.
// Ports:
//   aclk, aresetn  clock / asynchronous active-low reset
//   load           load load_val (has priority over dec)
//   load_val       W-bit value to load
//   dec            decrement by one; holds at zero, never wraps
//   zero           count is zero
module udp_sched_timer #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Saturating countdown so a stray dec at zero cannot underflow.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/udp_start_sched.sv
// udp_start_sched
//   Turns control-register writes into a paced sequence of UDP transmit
//   requests: req/ack/done handshake with the engine, programmable idle gap
//   between packets, packet counter and command-error reporting.
//   Optional macro UDP_TIMEOUT_EN adds a WAIT_DONE watchdog and timeout_o.
// Ports:
//   aclk, aresetn  clock / asynchronous active-low reset
//   data, wren     control word (bit0 START, bit1 STOP, [15:8] PKT_CNT,
//                  [31:16] GAP) and its write strobe
//   udp_req_o      request to the engine, held until acknowledged
//   udp_ack_i      engine accepted the request
//   udp_done_i     one-cycle pulse, packet fully sent
//   busy_o         scheduler not IDLE
//   pkt_sent_o     packets completed since reset (wraps)
//   cmd_err_o      one-cycle pulse on START while busy
//   timeout_o      sticky watchdog flag (UDP_TIMEOUT_EN only)
module udp_start_sched
  import udp_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic                  udp_req_o,
  input  logic                  udp_ack_i,
  input  logic                  udp_done_i,
  output logic                  busy_o,
  output logic [CNT_WIDTH-1:0]  pkt_sent_o,
  output logic                  cmd_err_o
`ifdef UDP_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  sched_state_t state;
  sched_state_t cpl_state;
  logic [7:0]   remaining;
  logic [15:0]  gap_reg;
  logic         continuous;
  logic         stop_pending;

  logic         wr_start;
  logic         wr_stop;
  logic [7:0]   cmd_cnt;
  logic [15:0]  cmd_gap;
  logic         completion;
  logic         gap_load;
  logic         gap_zero;

  assign wr_start = wren && data[START_BIT];
  assign wr_stop  = wren && data[STOP_BIT];
  assign cmd_cnt  = data[PKT_CNT_MSB:PKT_CNT_LSB];
  assign cmd_gap  = data[GAP_MSB:GAP_LSB];

  logic unused_data_bits;
  assign unused_data_bits = ^{data[PKT_CNT_LSB-1:STOP_BIT+1], data[DATA_WIDTH-1:GAP_MSB]};

  // A done pulse completes the packet either in WAIT_DONE or in REQ when it
  // coincides with the ack. cpl_state is where that completion leads.
  always_comb begin
    completion = udp_done_i &&
                 ((state == WAIT_DONE) || ((state == REQ) && udp_ack_i));
    if (stop_pending || (!continuous && (remaining == 8'd1))) begin
      cpl_state = IDLE;
    end else if (gap_reg == '0) begin
      cpl_state = REQ;
    end else begin
      cpl_state = GAP;
    end
    gap_load = completion && (cpl_state == GAP);
  end

  // Loaded with gap_reg-1 so GAP lasts exactly gap_reg cycles.
  udp_sched_timer #(.W(16)) u_gap_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (gap_load),
    .load_val (gap_reg - 16'd1),
    .dec      (state == GAP),
    .zero     (gap_zero)
  );

`ifdef UDP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic wd_zero;

  // Armed on entry to WAIT_DONE; reaches zero in the TIMEOUT_CYCLES-th cycle.
  udp_sched_timer #(.W(WD_W)) u_wd_timer (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     ((state == REQ) && udp_ack_i && !udp_done_i),
    .load_val (WD_W'(TIMEOUT_CYCLES - 1)),
    .dec      (state == WAIT_DONE),
    .zero     (wd_zero)
  );
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

  // Main FSM. Outputs are registered alongside the state; a completion is
  // handled after the case so it overrides the per-state defaults.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      udp_req_o    <= 1'b0;
      busy_o       <= 1'b0;
      pkt_sent_o   <= '0;
      cmd_err_o    <= 1'b0;
      remaining    <= '0;
      gap_reg      <= '0;
      continuous   <= 1'b0;
      stop_pending <= 1'b0;
`ifdef UDP_TIMEOUT_EN
      timeout_o    <= 1'b0;
`endif
    end else begin
      cmd_err_o <= wr_start && (state != IDLE);
      if (wr_stop && (state != IDLE)) begin
        stop_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          // START with STOP in the same word is treated as STOP.
          if (wr_start && !wr_stop) begin
            remaining  <= cmd_cnt;
            continuous <= (cmd_cnt == '0);
            gap_reg    <= cmd_gap;
            state      <= REQ;
            udp_req_o  <= 1'b1;
            busy_o     <= 1'b1;
`ifdef UDP_TIMEOUT_EN
            timeout_o  <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (udp_ack_i && !udp_done_i) begin
            state     <= WAIT_DONE;
            udp_req_o <= 1'b0;
          end
        end
        WAIT_DONE: begin
`ifdef UDP_TIMEOUT_EN
          if (!udp_done_i && wd_zero) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b1;
            stop_pending <= 1'b0;
          end
`endif
        end
        GAP: begin
          if (gap_zero) begin
            if (stop_pending) begin
              state        <= IDLE;
              busy_o       <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              state     <= REQ;
              udp_req_o <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (completion) begin
        pkt_sent_o <= pkt_sent_o + CNT_WIDTH'(1);
        if (!continuous) begin
          remaining <= remaining - 8'd1;
        end
        state     <= cpl_state;
        udp_req_o <= (cpl_state == REQ);
        busy_o    <= (cpl_state != IDLE);
        if (cpl_state == IDLE) begin
          stop_pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_start_sched.sv
// tb_udp_start_sched
//   Directed, table-driven bench for udp_start_sched. Each table row gives
//   the inputs presented for one rising edge and the outputs expected just
//   after it; hand-written sequences cover long ack stalls, asynchronous
//   reset and (with UDP_TIMEOUT_EN) the watchdog.
module tb_udp_start_sched;
  import udp_sched_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic        udp_ack_i = 1'b0;
  logic        udp_done_i = 1'b0;
  logic        udp_req_o;
  logic        busy_o;
  logic [15:0] pkt_sent_o;
  logic        cmd_err_o;
`ifdef UDP_TIMEOUT_EN
  logic        timeout_o;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 aclk = ~aclk;

  udp_start_sched #(
    .DATA_WIDTH     (32),
    .CNT_WIDTH      (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .data       (data),
    .wren       (wren),
    .udp_req_o  (udp_req_o),
    .udp_ack_i  (udp_ack_i),
    .udp_done_i (udp_done_i),
    .busy_o     (busy_o),
    .pkt_sent_o (pkt_sent_o),
    .cmd_err_o  (cmd_err_o)
`ifdef UDP_TIMEOUT_EN
    ,
    .timeout_o  (timeout_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        wren;
    logic [31:0] data;
    logic        ack;
    logic        done;
    logic        req;
    logic        busy;
    logic        err;
    logic [15:0] pkt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic w, input logic [31:0] d,
                              input logic a, input logic dn, input logic rq,
                              input logic bz, input logic er, input logic [15:0] pk);
    vec_t v;
    v.rst = rst; v.wren = w; v.data = d; v.ack = a; v.done = dn;
    v.req = rq; v.busy = bz; v.err = er; v.pkt = pk;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present inputs on the falling edge, let one rising edge pass, then
  // settle 1 time unit so the outputs reflect that edge.
  task automatic applyStimulus(input logic w, input logic [31:0] d,
                               input logic a, input logic dn);
    @(negedge aclk);
    wren = w; data = d; udp_ack_i = a; udp_done_i = dn;
    @(posedge aclk);
    #1;
  endtask

  task automatic doReset();
    @(negedge aclk);
    aresetn = 1'b0;
    wren = 1'b0; data = '0; udp_ack_i = 1'b0; udp_done_i = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic checkAll(input string tag, input logic rq, input logic bz,
                          input logic er, input logic [15:0] pk);
    checkOutput({tag, " req"},  udp_req_o,  rq);
    checkOutput({tag, " busy"}, busy_o,     bz);
    checkOutput({tag, " err"},  cmd_err_o,  er);
    checkOutput({tag, " pkt"},  pkt_sent_o, pk);
  endtask

  initial begin
    // Two packets, gap 3, ack one cycle after req, done five cycles later.
    vecs.push_back(mk(0, 1, 32'h0003_0201, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 0, 2));
    // Continuous, gap 0, STOP during the third WAIT_DONE.
    vecs.push_back(mk(1, 1, 32'h0000_0001, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 1, 32'h0000_0002, 0, 0, 0, 1, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 0, 3));
    // START while in WAIT_DONE: one-cycle error, single packet still ends.
    vecs.push_back(mk(0, 1, 32'h0000_0101, 0, 0, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 1, 32'h0005_0301, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 0, 0, 4));
    // START+STOP and STOP alone in IDLE do nothing.
    vecs.push_back(mk(0, 1, 32'h0000_0003, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 32'h0000_0002, 0, 0, 0, 0, 0, 4));

    // Outputs are zero while reset is held.
    repeat (2) @(posedge aclk);
    #1;
    checkAll("reset", 0, 0, 0, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].wren, vecs[i].data, vecs[i].ack, vecs[i].done);
      checkAll($sformatf("v%0d", i), vecs[i].req, vecs[i].busy, vecs[i].err, vecs[i].pkt);
    end

    // Ack held low for 20 cycles, then ack and done together.
    applyStimulus(1, 32'h0000_0101, 0, 0);
    checkOutput("stall start req", udp_req_o, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput($sformatf("stall req c%0d", i), udp_req_o, 1);
    end
    applyStimulus(0, 32'h0, 1, 1);
    checkAll("ackdone", 0, 0, 0, 5);
    applyStimulus(0, 32'h0, 0, 0);
    checkAll("ackdone hold", 0, 0, 0, 5);

    // Asynchronous reset in the middle of a gap.
    applyStimulus(1, 32'h0004_0201, 0, 0);
    applyStimulus(0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkAll("pre-reset gap", 0, 1, 0, 6);
    applyStimulus(0, 32'h0, 0, 0);
    #2;
    aresetn = 1'b0;
    #1;
    checkAll("async rst gap", 0, 0, 0, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    applyStimulus(1, 32'h0000_0101, 0, 0);
    checkAll("post-rst start", 1, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0);
    checkAll("post-rst ack", 0, 1, 0, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkAll("post-rst done", 0, 0, 0, 1);

    // Asynchronous reset while a request is raised drops it at once.
    applyStimulus(1, 32'h0000_0101, 0, 0);
    checkOutput("req before rst", udp_req_o, 1);
    #2;
    aresetn = 1'b0;
    #1;
    checkAll("async rst req", 0, 0, 0, 0);
    @(negedge aclk);
    aresetn = 1'b1;

`ifdef UDP_TIMEOUT_EN
    // Watchdog: no done for 16 WAIT_DONE cycles.
    applyStimulus(1, 32'h0000_0101, 0, 0);
    applyStimulus(0, 32'h0, 1, 0);
    repeat (15) applyStimulus(0, 32'h0, 0, 0);
    checkOutput("wd 15 busy", busy_o, 1);
    checkOutput("wd 15 timeout", timeout_o, 0);
    applyStimulus(0, 32'h0, 0, 0);
    checkAll("wd 16", 0, 0, 0, 0);
    checkOutput("wd 16 timeout", timeout_o, 1);
    applyStimulus(0, 32'h0, 0, 0);
    checkOutput("wd sticky", timeout_o, 1);
    applyStimulus(1, 32'h0000_0101, 0, 0);
    checkOutput("wd clear", timeout_o, 0);
    checkOutput("wd restart req", udp_req_o, 1);
    applyStimulus(0, 32'h0, 1, 1);
    checkAll("wd restart done", 0, 0, 0, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
